// File: rtl/interp_dac_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : interp_dac_buffer
// Description : Output stage behind the 8-phase polyphase interpolator.
//               Scales each signed 8-bit sample by a Q2.2 gain with
//               saturation, converts it to offset binary and queues it in a
//               show-ahead FIFO with a valid/ready handshake. Every
//               PHASE_NUM-th input sample is tagged as start-of-frame.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        i  upsampled clock (same as the interpolator clock)
//   rst_n      i  asynchronous active-low reset
//   in_valid   i  in_data/gain valid this cycle
//   in_data    i  signed two's-complement sample [7:0]
//   gain       i  unsigned Q2.2 gain [3:0] (value/4)
//   ovf_clr    i  synchronous clear of the sticky overflow flag
//   out_ready  i  consumer accepts the head entry this cycle
//   out_valid  o  out_data/out_sof hold a valid entry
//   out_data   o  offset-binary sample [7:0] (0x80 = zero)
//   out_sof    o  entry is the first of a PHASE_NUM group
//   level      o  entries held, output register included
//   overflow   o  sticky: a sample was dropped because the buffer was full
// ============================================================================
module interp_dac_buffer #(
    parameter int DEPTH     = 16,
    parameter int PHASE_NUM = 8,
    parameter int PHASE_BIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic [3:0]               gain,
    input  logic                     ovf_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_sof,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_LW       = c_AW + 1;
    // FIFO entries plus the show-ahead output register.
    localparam logic [c_AW:0]     c_FULL_LVL = c_LW'(DEPTH + 1);
    localparam logic [c_AW:0]     c_TWO      = c_LW'(2);
    localparam logic [PHASE_BIT-1:0] c_PH_LAST = PHASE_BIT'(PHASE_NUM - 1);
    // Reset value of the output register: sof=0, data = offset-binary zero.
    localparam logic [8:0]        c_OUT_RST  = 9'h080;
    localparam logic signed [12:0] c_SAT_HI  = 13'sd127;
    localparam logic signed [12:0] c_SAT_LO  = -13'sd128;

    // ------------------------------------------------------------------------
    // Stage 1: phase counter and scaling product
    // ------------------------------------------------------------------------
    logic [PHASE_BIT-1:0] ph_cnt_q, ph_cnt_d;
    logic                 v1_q,     v1_d;
    logic                 sof1_q,   sof1_d;
    logic signed [12:0]   prod_q,   prod_d;
    logic signed [12:0]   din_ext;
    logic signed [12:0]   gain_ext;

    always_comb begin
        din_ext  = {{5{in_data[7]}}, in_data};
        // Gain is unsigned; zero-extending keeps the product signed x unsigned.
        gain_ext = {9'b0, gain};
        v1_d     = in_valid;
        prod_d   = prod_q;
        sof1_d   = sof1_q;
        ph_cnt_d = ph_cnt_q;
        if (in_valid) begin
            // The true product fits in 13 bits (|-128 * 15| = 1920).
            prod_d   = din_ext * gain_ext;
            sof1_d   = (ph_cnt_q == '0);
            // Counts every input, accepted or dropped, so tags track the source.
            ph_cnt_d = (ph_cnt_q == c_PH_LAST) ? '0 : ph_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt_q <= '0;
            v1_q     <= 1'b0;
            sof1_q   <= 1'b0;
            prod_q   <= '0;
        end else begin
            ph_cnt_q <= ph_cnt_d;
            v1_q     <= v1_d;
            sof1_q   <= sof1_d;
            prod_q   <= prod_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: drop the Q2.2 fraction, saturate, convert to offset binary.
    // The converted word is registered into the write register; the FIFO
    // write or output bypass happens from there on the following edge.
    // ------------------------------------------------------------------------
    logic signed [12:0] scaled;
    logic signed [12:0] sat;
    logic [7:0]         word;
    logic               wr_v_q,    wr_v_d;
    logic [8:0]         wr_word_q, wr_word_d;

    always_comb begin
        scaled = prod_q >>> 2;
        if (scaled > c_SAT_HI) begin
            sat = c_SAT_HI;
        end else if (scaled < c_SAT_LO) begin
            sat = c_SAT_LO;
        end else begin
            sat = scaled;
        end
        word      = {~sat[7], sat[6:0]};
        wr_v_d    = v1_q;
        wr_word_d = v1_q ? {sof1_q, word} : wr_word_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v_q    <= 1'b0;
            wr_word_q <= '0;
        end else begin
            wr_v_q    <= wr_v_d;
            wr_word_q <= wr_word_d;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO with show-ahead output register
    // ------------------------------------------------------------------------
    logic [8:0]      mem_q [DEPTH];
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]   level_q,  level_d;
    logic            out_valid_q, out_valid_d;
    logic [8:0]      out_word_q,  out_word_d;
    logic            ovf_q,       ovf_d;

    logic consume;
    logic full;
    logic fifo_empty;
    logic wr_acc;
    logic drop;
    logic load;
    logic from_fifo;
    logic bypass;
    logic fifo_wr;

    always_comb begin
        consume    = out_valid_q & out_ready;
        full       = (level_q == c_FULL_LVL);
        // The output register is always filled before the memory, so at most
        // one entry held means the memory itself is empty.
        fifo_empty = (level_q < c_TWO);
        // A full buffer still takes a write when the head leaves that cycle.
        wr_acc     = wr_v_q & (~full | consume);
        drop       = wr_v_q & full & ~consume;
        load       = ~out_valid_q | consume;
        from_fifo  = load & ~fifo_empty;
        bypass     = load & fifo_empty & wr_acc;
        fifo_wr    = wr_acc & ~bypass;

        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        if (load) begin
            out_valid_d = from_fifo | bypass;
            if (from_fifo) begin
                out_word_d = mem_q[rd_ptr_q];
            end else if (bypass) begin
                out_word_d = wr_word_q;
            end
        end

        rd_ptr_d = rd_ptr_q;
        if (from_fifo) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        level_d = level_q;
        if (wr_acc && !consume) begin
            level_d = level_q + 1'b1;
        end else if (!wr_acc && consume) begin
            level_d = level_q - 1'b1;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Storage array carries no reset; stale entries are unreachable once the
    // pointers and level return to zero.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= wr_word_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= c_OUT_RST;
            ovf_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_word_q[7:0];
    assign out_sof   = out_word_q[8];
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_dac_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_interp_dac_buffer
// Description : Self-checking bench for interp_dac_buffer. A queue-based
//               reference model (buffer of DEPTH+1 entries behind a two-deep
//               pipeline) is stepped alongside the DUT; fixed vector tables
//               and hand-written sequences cover the corner cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_interp_dac_buffer;

    localparam int DEPTH     = 16;
    localparam int PHASE_NUM = 8;
    localparam int PHASE_BIT = 3;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic [3:0]    gain = '0;
    logic          ovf_clr = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_sof;
    logic [LW-1:0] level;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    interp_dac_buffer #(
        .DEPTH     (DEPTH),
        .PHASE_NUM (PHASE_NUM),
        .PHASE_BIT (PHASE_BIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .gain      (gain),
        .ovf_clr   (ovf_clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .level     (level),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [8:0] mq[$];
    bit         m_ovf;
    int         m_incnt;
    bit         p1_v;
    int         p1_d;
    int         p1_g;
    bit         p1_sof;
    bit         p2_v;
    logic [8:0] p2_w;

    function automatic logic [7:0] conv(input int d, input int g);
        int p;
        int s;
        p = d * g;
        // Floor division by 4 (the Q2.2 fraction is discarded toward -inf).
        s = (p < 0) ? -((-p + 3) / 4) : p / 4;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return 8'(s + 128);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_incnt = 0;
        p1_v    = 1'b0;
        p2_v    = 1'b0;
    endtask

    task automatic model_edge(input bit iv, input logic [7:0] d, input logic [3:0] g,
                              input bit rdy, input bit clr);
        bit drop;
        drop = 1'b0;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (p2_v) begin
            if (mq.size() < DEPTH + 1) mq.push_back(p2_w);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        p2_v = p1_v;
        if (p1_v) p2_w = {p1_sof, conv(p1_d, p1_g)};
        p1_v = iv;
        if (iv) begin
            p1_d    = int'($signed(d));
            p1_g    = int'(g);
            p1_sof  = ((m_incnt % PHASE_NUM) == 0);
            m_incnt = m_incnt + 1;
        end
    endtask

    task automatic compare_model();
        check("mdl_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("mdl_level", 32'(level), 32'(mq.size()));
        check("mdl_ovf", 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) begin
            check("mdl_data", 32'(out_data), 32'(mq[0][7:0]));
            check("mdl_sof", 32'(out_sof), 32'(mq[0][8]));
        end
    endtask

    // One clock: drive at the falling edge, step model on the rising edge,
    // compare 1 ns later.
    task automatic step(input bit iv, input logic [7:0] d, input logic [3:0] g,
                        input bit rdy, input bit clr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        gain      = g;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_edge(iv, d, g, rdy, clr);
        #1;
        compare_model();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'h80);
        check({tag, "_sof"},   32'(out_sof),   32'd0);
        check({tag, "_level"}, 32'(level),     32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #1;
        check_reset_state("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drain with out_ready high; expect data words first..first+n-1 at unity gain.
    task automatic drain(input string tag, input int first, input int n);
        int got[$];
        for (int k = 0; k < 60; k++) begin
            if (!out_valid) break;
            got.push_back(int'(out_data));
            step(1'b0, 8'h00, 4'd4, 1'b1, 1'b0);
        end
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int k = 0; k < got.size() && k < n; k++) begin
            check({tag, "_order"}, 32'(got[k]), 32'((first + k + 128) & 255));
        end
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        bit         iv;
        logic [7:0] d;
        logic [3:0] g;
        bit         ev;
        logic [7:0] ed;
        bit         es;
        int         el;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int sof_pos[$];
        int nout;

        // Unity gain endpoints, then saturation; out_ready held high.
        tbl[0] = '{1'b1, 8'h80, 4'd4,  1'b0, 8'h00, 1'b0, 0};
        tbl[1] = '{1'b1, 8'h00, 4'd4,  1'b0, 8'h00, 1'b0, 0};
        tbl[2] = '{1'b1, 8'h7F, 4'd4,  1'b1, 8'h00, 1'b1, 1};
        tbl[3] = '{1'b1, 8'h64, 4'd8,  1'b1, 8'h80, 1'b0, 1};
        tbl[4] = '{1'b1, 8'h9C, 4'd8,  1'b1, 8'hFF, 1'b0, 1};
        tbl[5] = '{1'b1, 8'h32, 4'd8,  1'b1, 8'hFF, 1'b0, 1};
        tbl[6] = '{1'b1, 8'hFF, 4'd15, 1'b1, 8'h00, 1'b0, 1};
        tbl[7] = '{1'b0, 8'h00, 4'd4,  1'b1, 8'hE4, 1'b0, 1};
        tbl[8] = '{1'b0, 8'h00, 4'd4,  1'b1, 8'h7C, 1'b0, 1};
        tbl[9] = '{1'b0, 8'h00, 4'd4,  1'b0, 8'h00, 1'b0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].g, 1'b1, 1'b0);
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            check("tbl_level", 32'(level), 32'(tbl[i].el));
            if (tbl[i].ev) begin
                check("tbl_data", 32'(out_data), 32'(tbl[i].ed));
                check("tbl_sof", 32'(out_sof), 32'(tbl[i].es));
            end
        end

        // Frame tag: 24 consecutive inputs, tags on outputs 0, 8, 16.
        do_reset();
        nout = 0;
        for (int i = 0; i < 26; i++) begin
            step(i < 24, 8'($urandom), 4'($urandom), 1'b1, 1'b0);
            if (out_valid) begin
                if (out_sof) sof_pos.push_back(nout);
                nout++;
            end
        end
        check("tag_count", 32'(nout), 32'd24);
        check("tag_num", 32'(sof_pos.size()), 32'd3);
        for (int k = 0; k < sof_pos.size() && k < 3; k++) begin
            check("tag_pos", 32'(sof_pos[k]), 32'(k * PHASE_NUM));
        end

        // Backpressure: 18 inputs into a stalled buffer; the last one drops.
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i), 4'd4, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 4'd4, 1'b0, 1'b0);
        check("bp_level", 32'(level), 32'(DEPTH + 1));
        check("bp_ovf", 32'(overflow), 32'd1);
        drain("bp_drain", 0, DEPTH + 1);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 4'd4, 1'b0, 1'b1);
        check("bp_ovf_clr", 32'(overflow), 32'd0);

        // Full buffer with a write and a consume on the same edges.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            step(c <= 21, 8'(c), 4'd4, (c >= 19), 1'b0);
            if (c >= 18) check("full_level", 32'(level), 32'(DEPTH + 1));
        end
        check("full_ovf", 32'(overflow), 32'd0);
        drain("full_drain", 5, DEPTH + 1);

        // Drop and clear on the same edge: set wins.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 4'd4, 1'b0, 1'b0);
        step(1'b1, 8'h11, 4'd4, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd4, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd4, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);

        // Asynchronous reset mid-burst with 9 entries held.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 4'd4, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 4'd4, 1'b0, 1'b0);
        check("mid_level", 32'(level), 32'd9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h33, 4'd4, 1'b1, 1'b0);
        step(1'b0, 8'h00, 4'd4, 1'b1, 1'b0);
        step(1'b0, 8'h00, 4'd4, 1'b1, 1'b0);
        check("mid_first_valid", 32'(out_valid), 32'd1);
        check("mid_first_data", 32'(out_data), 32'hB3);
        check("mid_first_sof", 32'(out_sof), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 10) < 7, 8'($urandom), 4'($urandom),
                 ($urandom % 10) < 6, ($urandom % 20) == 0);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 4'd4, 1'b1, 1'b0);
        check("rand_drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
